// File: rtl/adc_sequencer.sv
// AD7705 sequencer: hardware reset, per-channel register setup, then DRDY-polled 16-bit reads alternating across enabled channels.
// drdy pin to RQST is 3 clocks; every SPI byte waits for a spi_done rising edge, and the next byte waits for spi_done low.
module adc_sequencer #(
    parameter int         RESET_CYCLES   = 3000,
    parameter int         SETTLE_CYCLES  = 1500,
    parameter int         TIMEOUT_CYCLES = 65535,
    parameter logic [7:0] CLK_REG        = 8'h0C,
    parameter logic [7:0] SETUP_REG      = 8'h44
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  ch_en,
    input  logic        drdy,
    input  logic        spi_done,
    input  logic [7:0]  spi_rx,
    output logic        spi_transmit,
    output logic [7:0]  spi_tx,
    output logic        adc_reset,
    output logic [15:0] sample,
    output logic        sample_ch,
    output logic        sample_valid,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [3:0] RST_LO   = 4'd0;
    localparam logic [3:0] RST_WAIT = 4'd1;
    localparam logic [3:0] CFG      = 4'd2;
    localparam logic [3:0] IDLE     = 4'd3;
    localparam logic [3:0] POLL     = 4'd4;
    localparam logic [3:0] RQST     = 4'd5;
    localparam logic [3:0] RD_HI    = 4'd6;
    localparam logic [3:0] RD_LO    = 4'd7;
    localparam logic [3:0] EMIT     = 4'd8;

    localparam logic [15:0] RST_LAST    = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);

    logic [3:0]  state;
    logic [15:0] cnt;
    logic        drdy_meta;
    logic        drdy_sync;
    logic        done_q;
    logic        cfg_ch;
    logic        cfg_ch1_pending;
    logic [1:0]  cfg_idx;
    logic        ch;
    logic [7:0]  rd_hi;
    logic        byte_state;
    logic        byte_done;

    assign byte_state = (state == CFG) || (state == RQST) || (state == RD_HI) || (state == RD_LO);
    assign byte_done  = spi_transmit && spi_done && !done_q;
    assign adc_reset  = (state != RST_LO);
    assign busy       = (state != IDLE);

    // spi_tx is a pure function of state and byte index, both of which only move
    // on the edge that drops spi_transmit, so it is stable for the whole byte.
    always_comb begin
        spi_tx = 8'h00;
        case (state)
            CFG: begin
                case (cfg_idx)
                    2'd0:    spi_tx = 8'h20 | {7'd0, cfg_ch};
                    2'd1:    spi_tx = CLK_REG;
                    2'd2:    spi_tx = 8'h10 | {7'd0, cfg_ch};
                    default: spi_tx = SETUP_REG;
                endcase
            end
            RQST:    spi_tx = 8'h38 | {7'd0, ch};
            default: spi_tx = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= RST_LO;
            cnt             <= 16'd0;
            drdy_meta       <= 1'b1;
            drdy_sync       <= 1'b1;
            done_q          <= 1'b0;
            cfg_ch          <= 1'b0;
            cfg_ch1_pending <= 1'b0;
            cfg_idx         <= 2'd0;
            ch              <= 1'b0;
            rd_hi           <= 8'h00;
            spi_transmit    <= 1'b0;
            sample          <= 16'h0000;
            sample_ch       <= 1'b0;
            sample_valid    <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            drdy_meta <= drdy;
            drdy_sync <= drdy_meta;
            done_q    <= spi_done;

            if (byte_state) begin
                if (!spi_transmit && !spi_done)
                    spi_transmit <= 1'b1;
                else if (byte_done)
                    spi_transmit <= 1'b0;
            end

            case (state)
                RST_LO: begin
                    if (cnt == RST_LAST) begin
                        cnt   <= 16'd0;
                        state <= RST_WAIT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RST_WAIT: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt             <= 16'd0;
                        cfg_ch          <= !ch_en[0];
                        cfg_ch1_pending <= ch_en[0] && ch_en[1];
                        cfg_idx         <= 2'd0;
                        state           <= (ch_en == 2'b00) ? IDLE : CFG;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                CFG: begin
                    if (byte_done) begin
                        if (cfg_idx != 2'd3) begin
                            cfg_idx <= cfg_idx + 2'd1;
                        end else if (cfg_ch1_pending) begin
                            cfg_ch1_pending <= 1'b0;
                            cfg_ch          <= 1'b1;
                            cfg_idx         <= 2'd0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                IDLE: begin
                    if (enable && (ch_en != 2'b00)) begin
                        ch    <= !ch_en[0];
                        cnt   <= 16'd0;
                        state <= POLL;
                    end
                end
                POLL: begin
                    if (!drdy_sync) begin
                        cnt   <= 16'd0;
                        state <= RQST;
                    end else if (cnt == TMO_LAST) begin
                        cnt         <= 16'd0;
                        timeout_err <= 1'b1;
                        state       <= RST_LO;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RQST: begin
                    if (byte_done)
                        state <= RD_HI;
                end
                RD_HI: begin
                    if (byte_done) begin
                        rd_hi <= spi_rx;
                        state <= RD_LO;
                    end
                end
                RD_LO: begin
                    if (byte_done) begin
                        sample       <= {rd_hi, spi_rx};
                        sample_ch    <= ch;
                        sample_valid <= 1'b1;
                        state        <= EMIT;
                    end
                end
                EMIT: begin
                    sample_valid <= 1'b0;
                    // Next enabled channel, wrapping; a lone enabled channel repeats.
                    ch    <= (ch_en == 2'b11) ? !ch : ch_en[1];
                    cnt   <= 16'd0;
                    state <= (enable && (ch_en != 2'b00)) ? POLL : IDLE;
                end
                default: state <= RST_LO;
            endcase
        end
    end

endmodule
